uart_tx_buffered: RTL and testbench
===================================

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 2083, clk cycles per transmitted bit (legal range 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, transmit FIFO entries (power of 2, 2..256).
REQ-003 SHALL have port clk  input  1  module clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (one clock; reset asynchronous and active-low).
REQ-005 SHALL have port data  input  8  byte to enqueue.
REQ-006 SHALL have port wr  input  1  enqueue strobe, sampled each rising clk edge (level, not edge).
REQ-007 SHALL have port full  output  1  high when FIFO holds FIFO_DEPTH entries.
REQ-008 SHALL have port level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-009 SHALL have port overflow  output  1  sticky; set when wr is high while full.
REQ-010 SHALL have port busy  output  1  high whenever a frame is on the line.
REQ-011 SHALL have port tx  output  1  serial line, idle high, registered.

Function
REQ-012 SHALL accept a write on an edge where wr=1 and full=0; wr=1 with full=1 SHALL drop the byte and set overflow.
REQ-013 SHALL evaluate full before any same-edge pop; a simultaneous pop does not admit a write while full.
REQ-014 SHALL pop and write on the same edge when both occur and full=0; level unchanged.
REQ-015 SHALL keep FIFO read/write pointers modulo FIFO_DEPTH with an extra wrap bit; level = wptr - rptr.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-017 IDLE: if level!=0, pop head into shift register, tx<=0, baud counter<=0, go START; else tx<=1.
REQ-018 SHALL hold every bit for exactly BAUD_DIV clk cycles via a 0..BAUD_DIV-1 counter restarted at each bit boundary.
REQ-019 START -> DATA after BAUD_DIV cycles; DATA sends bits 0..7 LSB first, 3-bit index.
REQ-020 After bit 7, SHALL go to PARITY (macro) or STOP; STOP drives tx=1 for BAUD_DIV cycles.
REQ-021 At STOP end, if level!=0, SHALL pop and drive the next start bit on that same edge (no idle gap); else go IDLE.
REQ-022 Latency: byte written on edge k into an empty FIFO while IDLE SHALL drive tx low from edge k+1.
REQ-023 busy SHALL be high from the edge tx first falls until the edge STOP ends with an empty FIFO.
REQ-024 Frame length SHALL be 10*BAUD_DIV cycles (11*BAUD_DIV with parity).
REQ-025 overflow SHALL clear only by reset.

Reset
REQ-026 reset low SHALL immediately force tx=1, busy=0, overflow=0, level=0, full=0, state IDLE, counters 0.
REQ-027 reset asserted mid-frame SHALL abort the frame and discard all FIFO contents.
REQ-028 After reset deasserts, first possible write is on the next rising clk edge.

Configuration
REQ-029 Macro UART_TX_PARITY_EN defined: SHALL insert an even-parity bit (XOR of data bits) after bit 7, BAUD_DIV cycles long.
REQ-030 Macro undefined: SHALL omit PARITY state and logic; 8N1 framing.

Verification (BAUD_DIV=4, FIFO_DEPTH=8)
REQ-031 Write 0xA5 once while idle -> tx low at next edge; line sequence 0,1,0,1,0,0,1,0,1,1 each 4 cycles; busy high 40 cycles.
REQ-032 Write 0x00,0xFF on consecutive cycles -> two frames back-to-back, second start bit directly after first stop bit, 80 cycles total.
REQ-033 Write 9 bytes consecutively while IDLE -> all 9 accepted (first pops immediately), none dropped, overflow=0; 10th write while full -> dropped, overflow=1.
REQ-034 Assert reset during bit 3 of a frame with level=5 -> tx=1, level=0, busy=0 asynchronously; no further frames.
REQ-035 With UART_TX_PARITY_EN, write 0x07 -> parity bit 1, frame 44 cycles; without macro, frame 40 cycles.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO_DEPTH-entry byte FIFO feeding an 8N1 serial framer.
// Define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7 (8E1 framing).
module uart_tx_buffered #(
    parameter int unsigned BAUD_DIV   = 2083,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    data,
    input  logic                          wr,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          busy,
    output logic                          tx
);

    localparam int unsigned  AW        = $clog2(FIFO_DEPTH);
    localparam logic [15:0]  BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [AW:0]  DEPTH_W   = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]  PTR_ONE   = (AW+1)'(1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
`endif

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic        overflow_q, overflow_d;
    logic        push;
    logic        pop;
    logic        fifo_nonempty;
    logic [7:0]  head;

    // Pointers carry one extra wrap bit so that full and empty are distinguishable.
    assign level         = wptr_q - rptr_q;
    assign full          = (level == DEPTH_W);
    assign fifo_nonempty = (level != '0);
    assign head          = mem_q[rptr_q[AW-1:0]];

    // full is the registered occupancy, so a same-edge pop never makes room for a write.
    assign push       = wr && !full;
    assign wptr_d     = push ? (wptr_q + PTR_ONE) : wptr_q;
    assign rptr_d     = pop  ? (rptr_q + PTR_ONE) : rptr_q;
    assign overflow_d = overflow_q || (wr && full);

    // NOTE: storage has no reset; a reset empties the FIFO through the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= data;
        end
    end

    // ------------------------------------------------------------------
    // Framer
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        cnt_last;
    logic        launch;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    assign cnt_last = (cnt_q == BAUD_LAST);

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        launch    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        case (state_q)
            IDLE: begin
                if (fifo_nonempty) begin
                    launch = 1'b1;
                end else begin
                    tx_d = 1'b1;
                end
            end

            START: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            DATA: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif

            STOP: begin
                if (cnt_last) begin
                    // A queued byte starts on this very edge so frames run back-to-back.
                    if (fifo_nonempty) begin
                        launch = 1'b1;
                    end else begin
                        cnt_d   = '0;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: begin
                cnt_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        if (launch) begin
            shift_d   = head;
            tx_d      = 1'b0;
            cnt_d     = '0;
            bit_idx_d = '0;
            busy_d    = 1'b1;
            state_d   = START;
`ifdef UART_TX_PARITY_EN
            parity_d  = ^head;
`endif
        end
    end

    assign pop = launch;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered (BAUD_DIV=4, FIFO_DEPTH=8): directed steps plus a
// line monitor that decodes each frame and compares it against a byte scoreboard.
module tb_uart_tx_buffered;

    localparam int BAUD  = 4;
    localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data;
    logic       wr;
    logic       full;
    logic [3:0] level;
    logic       overflow;
    logic       busy;
    logic       tx;

    int checks   = 0;
    int failures = 0;
    logic [7:0] sb[$];

    uart_tx_buffered #(
        .BAUD_DIV   (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .data     (data),
        .wr       (wr),
        .full     (full),
        .level    (level),
        .overflow (overflow),
        .busy     (busy),
        .tx       (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FRAME_BITS-1:0] frame_of(input logic [7:0] b);
        logic [FRAME_BITS-1:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    task automatic put(input logic [7:0] b);
        data = b;
        wr   = 1'b1;
        sb.push_back(b);
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n;
        n = 0;
        while ((busy !== 1'b0 || level !== 4'd0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n >= limit), 32'd0);
    endtask

    // Line monitor: a low tx sample at a falling edge marks the first cycle of a start bit.
    initial begin : monitor
        logic [FRAME_BITS-1:0] obs;
        logic [7:0]            exp_b;
        logic                  first;
        bit                    stable;
        bit                    aborted;
        @(negedge clk);
        forever begin
            if (reset === 1'b1 && tx === 1'b0) begin
                aborted = 1'b0;
                obs     = '0;
                for (int b = 0; b < FRAME_BITS; b++) begin
                    first  = tx;
                    stable = 1'b1;
                    for (int c = 0; c < BAUD; c++) begin
                        if (reset !== 1'b1) aborted = 1'b1;
                        if (tx !== first) stable = 1'b0;
                        @(negedge clk);
                    end
                    obs[b] = stable ? first : 1'bx;
                end
                if (!aborted) begin
                    check("sb_underflow", 32'(sb.size() == 0), 32'd0);
                    if (sb.size() != 0) begin
                        exp_b = sb.pop_front();
                        check("frame", 32'(obs), 32'(frame_of(exp_b)));
                    end
                end
            end else begin
                @(negedge clk);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin : stimulus
        int n;
        reset = 1'b0;
        wr    = 1'b0;
        data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx",       32'(tx),       32'd1);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_level",    32'(level),    32'd0);
        check("rst_full",     32'(full),     32'd0);

        // Single byte straight after reset release; start bit one edge after the write.
        reset = 1'b1;
        put(8'hA5);
        wr = 1'b0;
        check("a5_tx_before", 32'(tx),    32'd1);
        check("a5_level_wr",  32'(level), 32'd1);
        @(negedge clk);
        check("a5_tx_start",  32'(tx),    32'd0);
        check("a5_busy",      32'(busy),  32'd1);
        check("a5_level_pop", 32'(level), 32'd0);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("a5_busy_len", n, 4 * FRAME_BITS);
        check("a5_tx_idle",  32'(tx), 32'd1);
        wait_idle("a5_idle", 100);

        // Two bytes on consecutive edges: second write coincides with the first pop.
        put(8'h00);
        put(8'hFF);
        wr = 1'b0;
        check("b2b_tx_start", 32'(tx),    32'd0);
        check("b2b_level",    32'(level), 32'd1);
        repeat (4 * FRAME_BITS) @(negedge clk);
        check("b2b_no_gap",   32'(tx),    32'd0);
        check("b2b_busy_mid", 32'(busy),  32'd1);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("b2b_busy_len2", n, 4 * FRAME_BITS);
        wait_idle("b2b_idle", 100);

        // Nine writes fill the FIFO behind the first pop; further writes are dropped.
        for (int i = 0; i < 9; i++) put(8'(i * 29 + 7));
        check("fill_level",    32'(level),    32'd8);
        check("fill_full",     32'(full),     32'd1);
        check("fill_overflow", 32'(overflow), 32'd0);
        data = 8'hEE;
        @(negedge clk);
        check("drop_overflow", 32'(overflow), 32'd1);
        check("drop_level",    32'(level),    32'd8);
        // Keep writing through the edge where the first stop bit ends and the head is popped.
        repeat (4 * FRAME_BITS - 8) @(negedge clk);
        wr = 1'b0;
        check("pop_while_full_level", 32'(level), 32'd7);
        check("overflow_sticky",      32'(overflow), 32'd1);
        wait_idle("fill_idle", 12 * 4 * FRAME_BITS);
        check("fill_sb_empty", 32'(sb.size()), 32'd0);

        // Reset during data bit 3 with five bytes queued.
        for (int i = 0; i < 6; i++) put(8'h50 + 8'(i));
        wr = 1'b0;
        repeat (12) @(negedge clk);
        check("rst_mid_level_before", 32'(level),    32'd5);
        check("rst_mid_ovf_before",   32'(overflow), 32'd1);
        #2;
        reset = 1'b0;
        sb.delete();
        #1;
        check("rst_mid_tx",       32'(tx),       32'd1);
        check("rst_mid_level",    32'(level),    32'd0);
        check("rst_mid_busy",     32'(busy),     32'd0);
        check("rst_mid_full",     32'(full),     32'd0);
        check("rst_mid_overflow", 32'(overflow), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) n++;
        end
        check("rst_no_frames", n, 0);

        // 0x07: parity bit is 1 when enabled; frame length follows the framing.
        put(8'h07);
        wr = 1'b0;
        @(negedge clk);
        check("p07_tx_start", 32'(tx), 32'd0);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("p07_busy_len", n, 4 * FRAME_BITS);
        wait_idle("p07_idle", 100);
        repeat (2) @(negedge clk);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
